// File: rtl/led_pattern_pkg.sv
// Shared mode encoding and widths for the LED pattern engine.
package led_pattern_pkg;

    localparam int unsigned MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD    = 3'd0,
        MODE_LOAD_LO = 3'd1,
        MODE_LOAD_HI = 3'd2,
        MODE_ROT_L   = 3'd3,
        MODE_ROT_R   = 3'd4,
        MODE_BOUNCE  = 3'd5
    } mode_e;

endpackage

// File: rtl/led_pattern_engine_if.sv
// Board-side bundle: mode/data from switches and buttons, led/dir/tick back out.
interface led_pattern_engine_if #(
    parameter int unsigned LED_W  = 16,
    parameter int unsigned DATA_W = 8
);
    import led_pattern_pkg::*;

    logic [MODE_W-1:0] mode;
    logic [DATA_W-1:0] data;
    logic [LED_W-1:0]  led;
    logic              dir;
    logic              tick;

    modport master (output mode, data, input led, dir, tick);
    modport slave  (input mode, data, output led, dir, tick);

endinterface

// File: rtl/led_pattern_engine_tick_gen.sv
// Step-rate prescaler: counts 0..TICK_DIV-1 and flags the last count with a registered pulse.
module tick_gen #(
    parameter int unsigned TICK_DIV = 4194304
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = (count == LAST) ? '0 : count + CNT_W'(1);
    end

    // tick is registered by looking one count ahead, so it is high exactly while count == LAST
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            count <= count_next;
            tick  <= (count_next == LAST);
        end
    end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern engine: synchronized switch/button inputs drive load/rotate/bounce steps on each tick.
// Define LED_BOUNCE_EN to build the bounce mode and the dir register; otherwise dir is tied to 0.
module led_pattern_engine
    import led_pattern_pkg::*;
#(
    parameter int unsigned LED_W    = 16,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned TICK_DIV = 4194304
) (
    input logic                 clk,
    input logic                 rst,
    led_pattern_engine_if.slave bus
);

    logic [MODE_W-1:0] mode_meta;
    logic [MODE_W-1:0] mode_sync;
    logic [DATA_W-1:0] data_meta;
    logic [DATA_W-1:0] data_sync;
    logic [LED_W-1:0]  led_q;
    logic [LED_W-1:0]  led_next;
    logic              tick;

`ifdef LED_BOUNCE_EN
    logic dir_q;
    logic dir_next;
`endif

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Two-flop synchronizers for the asynchronous board inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_meta <= '0;
            mode_sync <= '0;
            data_meta <= '0;
            data_sync <= '0;
        end else begin
            mode_meta <= bus.mode;
            mode_sync <= mode_meta;
            data_meta <= bus.data;
            data_sync <= data_meta;
        end
    end

    always_comb begin
        led_next = led_q;
`ifdef LED_BOUNCE_EN
        dir_next = dir_q;
`endif
        if (tick) begin
            case (mode_sync)
                MODE_LOAD_LO: begin
                    led_next = LED_W'(data_sync);
`ifdef LED_BOUNCE_EN
                    dir_next = 1'b0;
`endif
                end
                MODE_LOAD_HI: begin
                    led_next = LED_W'(data_sync) << (LED_W - DATA_W);
`ifdef LED_BOUNCE_EN
                    dir_next = 1'b0;
`endif
                end
                MODE_ROT_L: led_next = {led_q[LED_W-2:0], led_q[LED_W-1]};
                MODE_ROT_R: led_next = {led_q[0], led_q[LED_W-1:1]};
`ifdef LED_BOUNCE_EN
                // Reaching the edge in the current direction turns around on the same tick
                MODE_BOUNCE: begin
                    if (led_q != '0) begin
                        if (!dir_q) begin
                            if (led_q[LED_W-1]) begin
                                dir_next = 1'b1;
                                led_next = led_q >> 1;
                            end else begin
                                led_next = led_q << 1;
                            end
                        end else begin
                            if (led_q[0]) begin
                                dir_next = 1'b0;
                                led_next = led_q << 1;
                            end else begin
                                led_next = led_q >> 1;
                            end
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= '0;
`ifdef LED_BOUNCE_EN
            dir_q <= 1'b0;
`endif
        end else begin
            led_q <= led_next;
`ifdef LED_BOUNCE_EN
            dir_q <= dir_next;
`endif
        end
    end

    assign bus.led  = led_q;
    assign bus.tick = tick;
`ifdef LED_BOUNCE_EN
    assign bus.dir  = dir_q;
`else
    assign bus.dir  = 1'b0;
`endif

endmodule

// File: tb/tb_led_pattern_engine.sv
// Bench for led_pattern_engine: directed and random mode/data steps against an arithmetic reference model.
module tb_led_pattern_engine;

    localparam int unsigned LED_W    = 16;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned TICK_DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    led_pattern_engine_if #(.LED_W(LED_W), .DATA_W(DATA_W)) bus ();

    led_pattern_engine #(
        .LED_W    (LED_W),
        .DATA_W   (DATA_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int m_led    = 0;
    int m_dir    = 0;
    int cur_mode = 0;
    int cur_data = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference step computed from the mode table with plain integer arithmetic
    function automatic void model_step(input int md, input int d);
        int v;
        v = m_led;
        case (md)
            1: begin v = d;       m_dir = 0; end
            2: begin v = d * 256; m_dir = 0; end
            3: v = ((v * 2) % 65536) + (v / 32768);
            4: v = (v / 2) + ((v % 2) * 32768);
`ifdef LED_BOUNCE_EN
            5: if (v != 0) begin
                if (m_dir == 0) begin
                    if (v >= 32768) begin m_dir = 1; v = v / 2; end
                    else v = (v * 2) % 65536;
                end else begin
                    if (v % 2 == 1) begin m_dir = 0; v = (v * 2) % 65536; end
                    else v = v / 2;
                end
            end
`endif
            default: ;
        endcase
        m_led = v;
    endfunction

    task automatic apply(input int md, input int d);
        bus.mode = 3'(md);
        bus.data = 8'(d);
        cur_mode = md;
        cur_data = d;
    endtask

    // Called at the negedge just after a step edge (or reset release); runs exactly one step.
    task automatic step_once(input string tag);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 8) begin
            @(negedge clk);
            n++;
            check({tag, "_hold"}, 32'(bus.led), 32'(m_led));
            seen = bus.tick;
        end
        check({tag, "_period"}, 32'(n), TICK_DIV - 1);
        @(negedge clk);
        model_step(cur_mode, cur_data);
        check({tag, "_led"}, 32'(bus.led), 32'(m_led));
        check({tag, "_dir"}, 32'(bus.dir), 32'(m_dir));
        check({tag, "_tick_low"}, 32'(bus.tick), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        bus.mode = '0;
        bus.data = '0;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_led", 32'(bus.led), 32'd0);
        check("rst_dir", 32'(bus.dir), 32'd0);
        check("rst_tick", 32'(bus.tick), 32'd0);
        rst = 1'b0;
        apply(0, 0);
        step_once("first_tick");
        step_once("second_tick");

        apply(1, 'hA5); step_once("load_lo");
        check("load_lo_lit", 32'(bus.led), 32'h00A5);
        apply(2, 'hA5); step_once("load_hi");
        check("load_hi_lit", 32'(bus.led), 32'hA500);

        apply(1, 'h03); step_once("mk_0003");
        apply(4, 0);    step_once("mk_8001");
        check("mk_8001_lit", 32'(bus.led), 32'h8001);
        apply(3, 0);    step_once("rot_l_wrap");
        check("rot_l_lit", 32'(bus.led), 32'h0003);
        apply(4, 0);    step_once("rot_r_1");
        check("rot_r1_lit", 32'(bus.led), 32'h8001);
        step_once("rot_r_2");
        check("rot_r2_lit", 32'(bus.led), 32'hC000);

        apply(2, 'h40); step_once("bnc_load");
        apply(5, 0);
        for (int i = 0; i < 3; i++) step_once("bnc");
`ifdef LED_BOUNCE_EN
        check("bnc_2000_lit", 32'(bus.led), 32'h2000);
        check("bnc_dir_r", 32'(bus.dir), 32'd1);
`else
        check("bnc_off_lit", 32'(bus.led), 32'h4000);
        check("bnc_off_dir", 32'(bus.dir), 32'd0);
`endif
        for (int i = 0; i < 13; i++) step_once("bnc_run");
        step_once("bnc_turn");
`ifdef LED_BOUNCE_EN
        check("bnc_0002_lit", 32'(bus.led), 32'h0002);
        check("bnc_dir_l", 32'(bus.dir), 32'd0);
`else
        check("bnc_off_lit2", 32'(bus.led), 32'h4000);
`endif

        for (int i = 0; i < 48; i++) begin
            apply(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
            step_once("rand");
        end

        apply(1, 'hA5); step_once("rt_load");
        apply(3, 0);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 8) begin
            @(negedge clk);
            n++;
            seen = bus.tick;
        end
        check("rt_tick_found", 32'(seen), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        m_led = 0;
        m_dir = 0;
        check("rt_led", 32'(bus.led), 32'd0);
        check("rt_dir", 32'(bus.dir), 32'd0);
        check("rt_tick", 32'(bus.tick), 32'd0);
        rst = 1'b0;
        step_once("post_rst");
        apply(1, 'h5A); step_once("post_rst_load");
        check("post_rst_lit", 32'(bus.led), 32'h005A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
